// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the dmem_responder data-memory slave.
package dmem_responder_pkg;

  localparam int WORD_W = 32;
  localparam int STRB_W = WORD_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Misaligned word access or byte address beyond the array.
  function automatic logic addr_err(input logic [31:0] addr, input int depth_words);
    logic [33:0] limit;
    limit = 34'(depth_words) << 2;
    return (addr[1:0] != 2'b00) || ({2'b00, addr} >= limit);
  endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Word-organised storage with per-byte write enables and a combinational read port.
module dmem_responder_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic [AW-1:0]     idx,
  input  logic [STRB_W-1:0] wen,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (wen[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store responder: IDLE -> WAIT (WAIT_CYCLES) -> RESP.
// Optional access counters are built when DMEM_RESPONDER_STATS_EN is defined.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [31:0]       stat_reads,
  output logic [31:0]       stat_writes,
  output logic [31:0]       stat_errs
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WORD_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;

  logic              commit;
  logic              commit_err;
  logic [STRB_W-1:0] arr_wen;
  logic [WORD_W-1:0] arr_rdata;

  assign commit     = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  assign commit_err = addr_err(addr_q, DEPTH_WORDS);
  // A reset landing on the commit edge must abort the store.
  assign arr_wen    = (commit && !rst && we_q && !commit_err) ? wstrb_q : '0;

  dmem_responder_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk  (clk),
    .idx  (addr_q[AW+1:2]),
    .wen  (arr_wen),
    .wdata(wdata_q),
    .rdata(arr_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d        = req_we;
          addr_d      = req_addr;
          wdata_d     = req_wdata;
          wstrb_d     = req_wstrb;
          cnt_d       = 4'(WAIT_CYCLES);
          req_ready_d = 1'b0;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = commit_err;
          rsp_rdata_d = (!commit_err && !we_q) ? arr_rdata : '0;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Captured request fields are pure data and need no reset.
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

`ifdef DMEM_RESPONDER_STATS_EN
  logic [31:0] stat_reads_q, stat_reads_d;
  logic [31:0] stat_writes_q, stat_writes_d;
  logic [31:0] stat_errs_q, stat_errs_d;

  always_comb begin
    stat_reads_d  = stat_reads_q;
    stat_writes_d = stat_writes_q;
    stat_errs_d   = stat_errs_q;
    if (commit) begin
      if (commit_err)  stat_errs_d   = stat_errs_q + 32'd1;
      else if (we_q)   stat_writes_d = stat_writes_q + 32'd1;
      else             stat_reads_d  = stat_reads_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
      stat_errs_q   <= '0;
    end else begin
      stat_reads_q  <= stat_reads_d;
      stat_writes_q <= stat_writes_d;
      stat_errs_q   <= stat_errs_d;
    end
  end

  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;
  assign stat_errs   = stat_errs_q;
`else
  assign stat_reads  = '0;
  assign stat_writes = '0;
  assign stat_errs   = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: randomized loads/stores against a word-array model.
module tb_dmem_responder;

  localparam int DEPTH  = 1024;
  localparam int WAITC  = 2;
  localparam int NWORDS = 18;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] stat_reads, stat_writes, stat_errs;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_errs(stat_errs)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    bit          hold;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [NWORDS];
  int          n_reads = 0, n_writes = 0, n_errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (longint'(a) >= longint'(DEPTH) * 4);
  endfunction

  task automatic do_req(input bit we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit hold);
    exp_t e;
    int   w;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wstrb = s;
    w = 0;
    while (!req_ready) begin
      if (w > 300) begin
        checks++; failures++;
        $display("FAIL req_accept_timeout actual=req_ready_low required=accept");
        req_valid = 1'b0;
        return;
      end
      w++;
      @(negedge clk);
    end
    e.acc  = cyc + 1;
    e.hold = hold;
    e.err  = m_err(a);
    e.rdata = '0;
    if (e.err) n_errs++;
    else if (we) begin
      for (int b = 0; b < 4; b++) if (s[b]) mem_m[a >> 2][8*b +: 8] = d[8*b +: 8];
      n_writes++;
    end else begin
      e.rdata = mem_m[a >> 2];
      n_reads++;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_wstrb = 4'($urandom);
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge clk);
    while (!(sb.size() == 0 && req_ready && !rsp_valid)) begin
      if (w > 500) begin
        checks++; failures++;
        $display("FAIL idle_timeout actual=busy required=idle");
        return;
      end
      w++;
      @(negedge clk);
    end
  endtask

  // Response monitor: owns rsp_ready, pops the scoreboard on each new response.
  initial begin
    exp_t        e;
    bit          in_rsp = 0, pending = 0;
    int          hold_cnt = 0;
    logic [31:0] held_rdata;
    logic        held_err;
    rsp_ready = 1'b0;
    held_rdata = '0;
    held_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (pending) begin
          checks++; failures++;
          $display("FAIL rsp_not_released actual=rsp_valid_1 required=rsp_valid_0");
          pending = 0;
        end
        if (!in_rsp) begin
          in_rsp = 1;
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_rsp actual=rdata_%h required=no_response", rsp_rdata);
            hold_cnt = 0;
          end else begin
            e = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
            chk("latency", 32'(cyc - e.acc), 32'(WAITC + 1));
            hold_cnt = e.hold ? 5 : 0;
          end
          held_rdata = rsp_rdata;
          held_err   = rsp_err;
        end else begin
          chk("hold_rdata", rsp_rdata, held_rdata);
          chk("hold_err", 32'(rsp_err), 32'(held_err));
        end
        chk("resp_req_ready", 32'(req_ready), 32'd0);
        if (hold_cnt > 0) begin
          rsp_ready = 1'b0;
          hold_cnt--;
        end else begin
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
        pending = rsp_ready;
      end else begin
        if (pending) chk("post_hs_req_ready", 32'(req_ready), 32'd1);
        else if (in_rsp && !rst) begin
          checks++; failures++;
          $display("FAIL rsp_dropped actual=rsp_valid_0 required=rsp_valid_1");
        end
        pending = 0;
        in_rsp  = 0;
        rsp_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog actual=cycle_%0d required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int r;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(rsp_err), 32'd0);
    chk("reset_stat_reads", stat_reads, 32'd0);
    chk("reset_stat_errs", stat_errs, 32'd0);
    rst = 1'b0;

    for (int w = 0; w < NWORDS; w++) do_req(1'b1, 32'(w * 4), $urandom, 4'hF, 1'b0);

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);
    do_req(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0);
    do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 1'b0);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 1'b0);
    do_req(1'b0, 32'h13, 32'h0, 4'h0, 1'b0);
    do_req(1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 1'b0);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    do_req(1'b1, 32'h24, 32'h12345678, 4'h0, 1'b0);
    do_req(1'b0, 32'h24, 32'h0, 4'h0, 1'b0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);

    // Reset while a store of 0x55 to 0x40 is waiting.
    wait_idle();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h55; req_wstrb = 4'hF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_stat_writes", stat_writes, 32'd0);
    n_reads = 0; n_writes = 0; n_errs = 0;
    repeat (WAITC + 3) begin
      @(negedge clk);
      chk("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
    end
    do_req(1'b0, 32'h40, 32'h0, 4'h0, 1'b0);

    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'($urandom_range(0, NWORDS - 1) * 4 + $urandom_range(1, 3));
      else if (r == 1) a = ($urandom_range(0, 1) == 0) ? 32'(DEPTH * 4 + $urandom_range(0, NWORDS - 1) * 4)
                                                      : 32'hFFFF_FFFC;
      else             a = 32'($urandom_range(0, NWORDS - 1) * 4);
      do_req(1'($urandom), a, $urandom, 4'($urandom), ($urandom_range(0, 7) == 0));
    end

    wait_idle();
    repeat (2) @(negedge clk);
`ifdef DMEM_RESPONDER_STATS_EN
    chk("stat_reads", stat_reads, 32'(n_reads));
    chk("stat_writes", stat_writes, 32'(n_writes));
    chk("stat_errs", stat_errs, 32'(n_errs));
`else
    chk("stat_reads_tied", stat_reads, 32'd0);
    chk("stat_writes_tied", stat_writes, 32'd0);
    chk("stat_errs_tied", stat_errs, 32'd0);
`endif
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
